// File: rtl/vga_draw_pkg.sv
// vga_draw_pkg: screen geometry, field widths, scheduler states and named colours
package vga_draw_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int COLOR_W = 3;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;
  localparam logic [COLOR_W-1:0] BLACK = 3'd0;
  localparam logic [COLOR_W-1:0] BLUE = 3'd1;
  localparam logic [COLOR_W-1:0] RED = 3'd4;
  localparam logic [COLOR_W-1:0] WHITE = 3'd7;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set bit at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);
  // scan from farthest to nearest so the nearest requester at or after ptr wins
  always_comb begin
    idx = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        idx = IW'((int'(ptr) + i) % N);
        valid = 1'b1;
      end
    end
    gnt = valid ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: round-robin rectangle-fill engine emitting one clipped pixel per cycle
module draw_scheduler #(
  parameter int NREQ = 4,
  parameter int X_W = vga_draw_pkg::X_W,
  parameter int Y_W = vga_draw_pkg::Y_W,
  parameter int COLOR_W = vga_draw_pkg::COLOR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*X_W-1:0]     req_x0,
  input  logic [NREQ*Y_W-1:0]     req_y0,
  input  logic [NREQ*X_W-1:0]     req_w,
  input  logic [NREQ*Y_W-1:0]     req_h,
  input  logic [NREQ*COLOR_W-1:0] req_color,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [X_W-1:0]          vga_x,
  output logic [Y_W-1:0]          vga_y,
  output logic [COLOR_W-1:0]      vga_color,
  output logic                    vga_plot
);
  import vga_draw_pkg::*;
  localparam int IW = $clog2(NREQ);
  localparam logic [X_W:0] SW = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SH = (Y_W+1)'(SCREEN_H);
  state_t state, state_n;
  logic [IW-1:0] ptr, win, arb_idx;
  logic [NREQ-1:0] arb_gnt, win_oh;
  logic arb_valid;
  logic [X_W-1:0] x0, w, x0_l;
  logic [Y_W-1:0] y0, h;
  logic [COLOR_W-1:0] col;
  logic [X_W:0] x_sum, x_end, x_end_l;
  logic [Y_W:0] y_sum, y_end, y_end_l;
  logic empty, last_col, last_row;
  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req(req), .ptr(ptr), .gnt(arb_gnt), .idx(arb_idx), .valid(arb_valid)
  );
  assign x0 = req_x0[win*X_W +: X_W];
  assign y0 = req_y0[win*Y_W +: Y_W];
  assign w = req_w[win*X_W +: X_W];
  assign h = req_h[win*Y_W +: Y_W];
  assign col = req_color[win*COLOR_W +: COLOR_W];
  assign x_sum = {1'b0, x0} + {1'b0, w};
  assign y_sum = {1'b0, y0} + {1'b0, h};
  assign x_end = (x_sum > SW) ? SW : x_sum;
  assign y_end = (y_sum > SH) ? SH : y_sum;
  assign empty = (w == '0) || (h == '0) || ({1'b0, x0} >= SW) || ({1'b0, y0} >= SH);
  assign last_col = ({1'b0, vga_x} + (X_W+1)'(1)) == x_end_l;
  assign last_row = ({1'b0, vga_y} + (Y_W+1)'(1)) == y_end_l;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // next-state: serve, latch, raster scan, report
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE: state_n = arb_valid ? LOAD : IDLE;
      LOAD: state_n = empty ? DONE : DRAW;
      DRAW: state_n = (last_col && last_row) ? DONE : DRAW;
      default: state_n = IDLE;
    endcase
  end
  // state-decoded outputs; plot drops with state on async reset
  always_comb begin
    busy = state != IDLE;
    vga_plot = state == DRAW;
    grant = (state == LOAD) ? win_oh : '0;
    done = (state == DONE) ? win_oh : '0;
  end
  // winner, latched rectangle, pixel cursor held in the output registers, rotation pointer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ptr <= '0;
      win <= '0;
      win_oh <= '0;
      x0_l <= '0;
      x_end_l <= '0;
      y_end_l <= '0;
      vga_x <= '0;
      vga_y <= '0;
      vga_color <= '0;
    end else begin
      if (state == IDLE && arb_valid) begin
        win <= arb_idx;
        win_oh <= arb_gnt;
      end
      if (state == LOAD && !empty) begin
        x0_l <= x0;
        x_end_l <= x_end;
        y_end_l <= y_end;
        vga_x <= x0;
        vga_y <= y0;
        vga_color <= col;
      end
      if (state == DRAW && !last_col) vga_x <= vga_x + X_W'(1);
      if (state == DRAW && last_col && !last_row) begin
        vga_x <= x0_l;
        vga_y <= vga_y + Y_W'(1);
      end
      if (state == DONE) ptr <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
    end
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: directed scoreboard bench for the rectangle scheduler
module tb_draw_scheduler;
  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic [35:0] req_x0, req_w;
  logic [31:0] req_y0, req_h;
  logic [11:0] req_color;
  logic [3:0] grant, done;
  logic busy, vga_plot;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_color;
  pix_t exp_q[$];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  draw_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .req_x0(req_x0), .req_y0(req_y0),
    .req_w(req_w), .req_h(req_h), .req_color(req_color), .grant(grant),
    .done(done), .busy(busy), .vga_x(vga_x), .vga_y(vga_y),
    .vga_color(vga_color), .vga_plot(vga_plot)
  );
  // every plotted pixel must be the next expected one
  always @(negedge clk)
    if (vga_plot) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $error("FAIL pixel_unexpected observed=(%0d,%0d,%0d) expected=none", vga_x, vga_y, vga_color);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        assert ({vga_x, vga_y, vga_color} === e) else begin
          bad = bad + 1;
          $error("FAIL pixel observed=(%0d,%0d,%0d) expected=(%0d,%0d,%0d)", vga_x, vga_y, vga_color, e.x, e.y, e.c);
        end
      end
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_rect(input int c, input int x0, input int y0, input int w, input int h, input int col);
    req_x0[c*9 +: 9] = 9'(x0);
    req_y0[c*8 +: 8] = 8'(y0);
    req_w[c*9 +: 9] = 9'(w);
    req_h[c*8 +: 8] = 8'(h);
    req_color[c*3 +: 3] = 3'(col);
  endtask
  task automatic push_rect(input int x0, input int y0, input int w, input int h, input int col);
    int xe, ye;
    xe = (x0 + w > 320) ? 320 : x0 + w;
    ye = (y0 + h > 240) ? 240 : y0 + h;
    if (w == 0 || h == 0 || x0 >= 320 || y0 >= 240) return;
    for (int y = y0; y < ye; y++)
      for (int x = x0; x < xe; x++)
        exp_q.push_back(pix_t'{9'(x), 8'(y), 3'(col)});
  endtask
  task automatic serve(input int c, input int p, input logic [3:0] drop, input bit scramble);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_plot", 32'(vga_plot), 0);
    @(negedge clk);
    chk("grant", 32'(grant), 32'(1) << c);
    chk("load_busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    req = req & ~drop;
    if (scramble) set_rect(c, 0, 0, 9, 9, 1);
    for (int k = 0; k < p; k++) begin
      @(negedge clk);
      chk("plot_on", 32'(vga_plot), 1);
    end
    @(negedge clk);
    chk("done", 32'(done), 32'(1) << c);
    chk("done_plot", 32'(vga_plot), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);
  endtask
  initial begin
    rst = 1'b0;
    req = '0;
    req_x0 = '0;
    req_y0 = '0;
    req_w = '0;
    req_h = '0;
    req_color = '0;
    #1;
    chk("rst_outputs", {grant, done, busy, vga_plot, vga_x, vga_y, vga_color}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) set_rect(i, 10 + i, 20, 1, 1, i + 1);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push_rect(10 + k % 4, 20, 1, 1, k % 4 + 1);
      serve(k % 4, 1, (k == 4) ? 4'b1111 : 4'b0000, 0);
    end
    set_rect(0, 100, 100, 3, 2, 7);
    req = 4'b0001;
    push_rect(100, 100, 3, 2, 7);
    serve(0, 6, 4'b0001, 0);
    set_rect(3, 50, 50, 0, 4, 1);
    req = 4'b1000;
    serve(3, 0, 4'b1000, 0);
    set_rect(0, 320, 10, 2, 2, 1);
    req = 4'b0001;
    serve(0, 0, 4'b0001, 0);
    set_rect(1, 200, 50, 2, 2, 4);
    req = 4'b0010;
    push_rect(200, 50, 2, 2, 4);
    serve(1, 4, 4'b0010, 1);
    set_rect(2, 318, 239, 5, 5, 4);
    req = 4'b0100;
    push_rect(318, 239, 5, 5, 4);
    serve(2, 2, 4'b0100, 0);
    set_rect(3, 0, 0, 100, 100, 2);
    req = 4'b1000;
    push_rect(0, 0, 100, 100, 2);
    @(negedge clk);
    chk("fill_idle", 32'(busy), 0);
    @(negedge clk);
    chk("fill_grant", 32'(grant), 32'h8);
    @(posedge clk);
    #1;
    req = '0;
    repeat (50) @(negedge clk);
    chk("fill_plotting", 32'(vga_plot), 1);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_plot", 32'(vga_plot), 0);
    chk("abort_outputs", {grant, done, busy, vga_x, vga_y, vga_color}, 0);
    chk("abort_consumed", 32'(exp_q.size()), 9950);
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("abort_no_done", 32'(done), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    set_rect(2, 5, 5, 1, 1, 3);
    set_rect(3, 6, 6, 1, 1, 4);
    req = 4'b1100;
    push_rect(5, 5, 1, 1, 3);
    serve(2, 1, 4'b0100, 0);
    push_rect(6, 6, 1, 1, 4);
    serve(3, 1, 4'b1000, 0);
    @(negedge clk);
    chk("final_idle", 32'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Shared rectangle-fill engine and round-robin scheduler in front of the VGA framebuffer write port (`color`, `x`, `y`, `plot` of `vga_adapter`). Up to `NREQ` drawing clients each request one filled rectangle: the grid lines, X marks, O marks and the cursor highlight. The block grants one client at a time, latches its rectangle, and emits exactly one clipped pixel write per cycle in raster order. Completion is signalled back to the granted client.

## Interface

Parameters:
- `NREQ`, 4: number of requesters.
- `X_W`, 9: pixel x width, 320-wide screen.
- `Y_W`, 8: pixel y width, 240-tall screen.
- `COLOR_W`, 3: colour width.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `req`  in  `NREQ`: per-client draw request, level.
- `req_x0`  in  `NREQ*X_W`: per-client left edge, client i at slice [i*X_W +: X_W].
- `req_y0`  in  `NREQ*Y_W`: per-client top edge.
- `req_w`  in  `NREQ*X_W`: per-client width in pixels.
- `req_h`  in  `NREQ*Y_W`: per-client height in pixels.
- `req_color`  in  `NREQ*COLOR_W`: per-client fill colour.
- `grant`  out  `NREQ`: one-hot, one-cycle pulse when a client's rectangle is latched.
- `done`  out  `NREQ`: one-hot, one-cycle pulse when that client's rectangle is finished.
- `busy`  out  1: high in every state except IDLE.
- `vga_x`  out  `X_W`: pixel x to adapter.
- `vga_y`  out  `Y_W`: pixel y to adapter.
- `vga_color`  out  `COLOR_W`: pixel colour to adapter.
- `vga_plot`  out  1: write enable to adapter.

## Operation

- States: IDLE, LOAD, DRAW, DONE.
- Encoding is 2 bits. Unreachable codes return to IDLE.
- **IDLE**: if any `req` bit is set, select the winner round-robin. Search starts at `ptr`, the index after the last granted client, then goes to LOAD.
- **LOAD**: pulse `grant[win]`. Latch the rectangle and compute clipped bounds in X_W+1 / Y_W+1 bit arithmetic:
  - x_end = min(x0+w, 320)
  - y_end = min(y0+h, 240)
  - The rectangle is empty if w==0, h==0, x0>=320 or y0>=240.
  - Empty rectangle goes to DONE. Otherwise set cx=x0, cy=y0 and go to DRAW.
- **DRAW**: each cycle, register `vga_x`=cx, `vga_y`=cy, `vga_color`=latched colour, `vga_plot`=1.
  - Then cx++. When cx+1==x_end: cx=x0 and cy++.
  - Leave for DONE after the pixel (x_end-1, y_end-1) is issued.
- **DONE**: pulse `done[win]`, set `ptr`=win+1 mod NREQ, go to IDLE.
- Handshake rules:
  - A client holds `req` and its rectangle stable until `grant`.
  - After `grant` the client may change its rectangle or drop `req`; the latched copy is used.
  - A client still asserting `req` at the next IDLE is served again, subject to round-robin.
  - Dropping `req` before `grant` cancels the request with no side effects.
- Simultaneous requests: the lowest index at or after `ptr` wins. `ptr` resets to 0.
- `vga_plot` is 0 in IDLE, LOAD and DONE. `vga_x`, `vga_y` and `vga_color` hold their last values.

## Timing

- Reset values:
  - `grant`=0, `done`=0, `busy`=0, `vga_plot`=0.
  - `vga_x`=0, `vga_y`=0, `vga_color`=0.
  - state=IDLE, `ptr`=0.
- Reset mid-DRAW drops `vga_plot` asynchronously. The rectangle is abandoned and no `done` is issued.
- A request sampled in IDLE at cycle 0 gives:
  - `grant` in cycle 1.
  - Pixels P=(cw*ch) in cycles 2..P+1, where cw and ch are the clipped width and height.
  - `done` in cycle P+2.
  - IDLE in cycle P+3.
- Empty rectangle: `grant` in cycle 1, `done` in cycle 2.
- Throughput is 1 pixel/cycle. Overhead is 3 cycles per rectangle.

## Structure

- Package `vga_draw_pkg` holds:
  - SCREEN_W=320, SCREEN_H=240.
  - X_W, Y_W, COLOR_W.
  - The state encoding.
  - Named colours: BLACK=0, WHITE=7, RED=4, BLUE=1.
- Sub-module `rr_arbiter`: combinational `req` + `ptr` → one-hot winner plus index. It is reused by future input-event arbitration.

## Test plan

- Client 0 requests x0=100, y0=100, w=3, h=2, colour 7:
  - `grant[0]` in cycle 1.
  - Six plots in cycles 2-7: (100,100),(101,100),(102,100),(100,101),(101,101),(102,101).
  - `done[0]` in cycle 8.
- `req`=4'b1111 held continuously with 1×1 rectangles: grants in order 0,1,2,3,0.
- Clipping, x0=318, y0=239, w=5, h=5: exactly 2 plots, (318,239) and (319,239). w=0: `grant` then `done` one cycle apart, no plot.
- Client 1 changes its rectangle the cycle after `grant`: the pixels still match the original latched rectangle.
- `rst` low during a 100×100 fill at pixel 50:
  - `vga_plot` falls immediately and all outputs go to 0.
  - After release, a new request from client 2 is granted with `ptr`=0 behaviour.
